// File: rtl/arena_init_seq_pkg.sv
// ---------------------------------------------------------------------------
// arena_pkg
// Shared definitions for the arena/round initialiser:
//   - cell codes written into the arena RAM
//   - initialiser FSM state encoding
//   - LFSR default seed, tap mask and single-step helper
// Configuration macro (used by the files importing this package):
//   ARENA_INIT_LFSR_EN - enables pseudo-random filler blocks.
// ---------------------------------------------------------------------------
package arena_pkg;

    // Arena cell codes
    localparam logic [1:0] CELL_BLANK    = 2'd0;
    localparam logic [1:0] CELL_BLOCK    = 2'd1;
    localparam logic [1:0] CELL_PLAYER_A = 2'd2;
    localparam logic [1:0] CELL_PLAYER_B = 2'd3;

    // Initialiser sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A zero seed would lock the LFSR at zero, so it is replaced by this value.
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/arena_init_seq_if.sv
// ---------------------------------------------------------------------------
// arena_init_seq_if
// Shared write port into the arena and bomb RAMs.
//   wr_en       - write strobe for both RAMs
//   wr_addr     - cell index (row*COLS + col)
//   arena_wdata - arena cell code
//   bomb_wdata  - bomb RAM cell value
// Modports: master (initialiser drives), slave (RAMs / observers).
// ---------------------------------------------------------------------------
interface arena_init_seq_if #(
    parameter int ADDR_W = 7,
    parameter int CELL_W = 2
) ();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CELL_W-1:0] arena_wdata;
    logic [1:0]        bomb_wdata;

    modport master (
        output wr_en,
        output wr_addr,
        output arena_wdata,
        output bomb_wdata
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input arena_wdata,
        input bomb_wdata
    );

endinterface

// File: rtl/arena_init_seq_lfsr.sv
// ---------------------------------------------------------------------------
// arena_lfsr
// 16-bit Galois LFSR used to scatter random blocks over the arena.
// Only instantiated when ARENA_INIT_LFSR_EN is defined.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (loads from seed, like a fill start)
//   load - load from seed (zero seed maps to LFSR_DEFAULT_SEED)
//   step - advance one state
//   seed - load value
//   q    - current LFSR state
// ---------------------------------------------------------------------------
module arena_lfsr
    import arena_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] load_val;

    assign load_val = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    // Reset restarts a fill, so it loads the seed exactly like a start pulse.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q_q <= load_val;
        end else if (step) begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/arena_init_seq.sv
// ---------------------------------------------------------------------------
// arena_init_seq
// Arena/round initialiser for the bomb game. Streams a ROWS x COLS arena
// into the arena and bomb RAMs one cell per clock, then reloads player
// health and game state. Runs after reset and on each accepted start pulse.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - one-cycle new-round request, honoured only when idle
//   seed         - LFSR seed sampled at fill start (ARENA_INIT_LFSR_EN only)
//   busy         - high while a fill is in progress (including done cycle)
//   done         - one-cycle pulse after the last cell write
//   healthA/B    - player health
//   game_state   - 0 = playing
//   wr           - arena/bomb RAM write port (master)
// Configuration: define ARENA_INIT_LFSR_EN to add random filler blocks.
// ---------------------------------------------------------------------------
module arena_init_seq
    import arena_pkg::*;
#(
    parameter int ROWS        = 10,
    parameter int COLS        = 10,
    parameter int CELL_W      = 2,
    parameter int HEALTH_W    = 2,
    parameter int HEALTH_INIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef ARENA_INIT_LFSR_EN
    input  logic [15:0]         seed,
`endif
    output logic                busy,
    output logic                done,
    output logic [HEALTH_W-1:0] healthA,
    output logic [HEALTH_W-1:0] healthB,
    output logic [1:0]          game_state,
    arena_init_seq_if.master    wr
);

    localparam int ADDR_W = $clog2(ROWS * COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);

    localparam logic [ROW_W-1:0]    ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0]    COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]    ROW_B    = ROW_W'(ROWS - 2);
    localparam logic [COL_W-1:0]    COL_B    = COL_W'(COLS - 2);
    localparam logic [HEALTH_W-1:0] HP_INIT  = HEALTH_W'(HEALTH_INIT);

    // ------------------------------------------------------------------
    // Cell layout rules
    // ------------------------------------------------------------------
    // True when (r,c) is a direct orthogonal neighbour of (sr,sc).
    // Spawn coordinates are never on the border, so sr-1/sc-1 cannot wrap
    // and sr+1/sc+1 stay inside the counter range.
    function automatic logic is_adjacent(
        input logic [ROW_W-1:0] r,
        input logic [COL_W-1:0] c,
        input logic [ROW_W-1:0] sr,
        input logic [COL_W-1:0] sc
    );
        return ((r == sr) && ((c == sc + COL_ONE) || (c == sc - COL_ONE))) ||
               ((c == sc) && ((r == sr + ROW_ONE) || (r == sr - ROW_ONE)));
    endfunction

    function automatic logic [CELL_W-1:0] cell_code(
        input logic [ROW_W-1:0] r,
        input logic [COL_W-1:0] c,
        input logic             rnd_block
    );
        logic [CELL_W-1:0] code;
        if (r == '0 || r == ROW_LAST || c == '0 || c == COL_LAST) begin
            code = CELL_W'(CELL_BLOCK);
        end else if (r == ROW_ONE && c == COL_ONE) begin
            code = CELL_W'(CELL_PLAYER_A);
        end else if (r == ROW_B && c == COL_B) begin
            code = CELL_W'(CELL_PLAYER_B);
        end else if (is_adjacent(r, c, ROW_ONE, COL_ONE) ||
                     is_adjacent(r, c, ROW_B, COL_B)) begin
            code = CELL_W'(CELL_BLANK);       // keep spawns free to move
        end else if (!r[0] && !c[0]) begin
            code = CELL_W'(CELL_BLOCK);       // indestructible pillar grid
        end else begin
            code = rnd_block ? CELL_W'(CELL_BLOCK) : CELL_W'(CELL_BLANK);
        end
        return code;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,       state_d;
    logic [ROW_W-1:0]    row_q,         row_d;
    logic [COL_W-1:0]    col_q,         col_d;
    logic [ADDR_W-1:0]   idx_q,         idx_d;
    logic                wr_en_q,       wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,     wr_addr_d;
    logic [CELL_W-1:0]   arena_wdata_q, arena_wdata_d;
    logic                busy_q,        busy_d;
    logic                done_q,        done_d;
    logic [HEALTH_W-1:0] health_a_q,    health_a_d;
    logic [HEALTH_W-1:0] health_b_q,    health_b_d;
    logic [1:0]          game_state_q,  game_state_d;
    logic                rnd_block;

`ifdef ARENA_INIT_LFSR_EN
    logic [15:0] lfsr_q;
    logic        lfsr_load;
    logic        lfsr_step;

    assign lfsr_load = (state_q == ST_IDLE) && start;
    assign lfsr_step = (state_q == ST_FILL);

    arena_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (seed),
        .q    (lfsr_q)
    );

    // Roughly 3/8 of the free cells become destructible blocks.
    assign rnd_block = (lfsr_q[2:0] < 3'd3);
`else
    assign rnd_block = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        idx_d         = idx_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        arena_wdata_d = arena_wdata_q;
        done_d        = 1'b0;
        // Registered one cycle behind the state so busy lines up with the
        // registered write strobe and stays high through the done pulse.
        busy_d        = (state_q != ST_IDLE);
        health_a_d    = health_a_q;
        health_b_d    = health_b_q;
        game_state_d  = game_state_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_FILL: begin
                wr_en_d       = 1'b1;
                wr_addr_d     = idx_q;
                arena_wdata_d = cell_code(row_q, col_q, rnd_block);
                idx_d         = idx_q + ADDR_W'(1);
                // Explicit end-of-row compare keeps non-power-of-2 sizes
                // from ever reaching an out-of-range column or address.
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            ST_DONE: begin
                done_d       = 1'b1;
                health_a_d   = HP_INIT;
                health_b_d   = HP_INIT;
                game_state_d = 2'd0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            row_q         <= '0;
            col_q         <= '0;
            idx_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            arena_wdata_q <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            health_a_q    <= HP_INIT;
            health_b_q    <= HP_INIT;
            game_state_q  <= 2'd0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            idx_q         <= idx_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            arena_wdata_q <= arena_wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            health_a_q    <= health_a_d;
            health_b_q    <= health_b_d;
            game_state_q  <= game_state_d;
        end
    end

    assign wr.wr_en       = wr_en_q;
    assign wr.wr_addr     = wr_addr_q;
    assign wr.arena_wdata = arena_wdata_q;
    assign wr.bomb_wdata  = 2'b00;     // a new round starts with no bombs

    assign busy       = busy_q;
    assign done       = done_q;
    assign healthA    = health_a_q;
    assign healthB    = health_b_q;
    assign game_state = game_state_q;

endmodule

// File: tb/tb_arena_init_seq.sv
// ---------------------------------------------------------------------------
// tb_arena_init_seq
// Drives two initialisers (10x10 and 7x13) with randomised round starts,
// stray start pulses and mid-fill resets. Expected writes and done pulses
// come from a rule-based arena model and are queued when stimulus is issued;
// negedge monitors pop and compare whenever the DUTs present an output.
// ---------------------------------------------------------------------------
module tb_arena_init_seq;
    import arena_pkg::*;

    localparam int RA = 10, CA = 10, NA = RA * CA;
    localparam int RB = 7,  CB = 13, NB = RB * CB;
    localparam int AW_A = $clog2(NA);
    localparam int AW_B = $clog2(NB);

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [15:0] seed_a = 16'h0, seed_b = 16'h0;
    logic busy_a, busy_b, done_a, done_b;
    logic [1:0] hpa_a, hpb_a, hpa_b, hpb_b, gs_a, gs_b;

    arena_init_seq_if #(.ADDR_W(AW_A), .CELL_W(2)) if_a ();
    arena_init_seq_if #(.ADDR_W(AW_B), .CELL_W(2)) if_b ();

    arena_init_seq #(.ROWS(RA), .COLS(CA)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a),
`ifdef ARENA_INIT_LFSR_EN
        .seed(seed_a),
`endif
        .busy(busy_a), .done(done_a), .healthA(hpa_a), .healthB(hpb_a),
        .game_state(gs_a), .wr(if_a)
    );

    arena_init_seq #(.ROWS(RB), .COLS(CB)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b),
`ifdef ARENA_INIT_LFSR_EN
        .seed(seed_b),
`endif
        .busy(busy_b), .done(done_b), .healthA(hpa_b), .healthB(hpb_b),
        .game_state(gs_b), .wr(if_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t wq0[$];
    exp_t wq1[$];
    int   dq0[$];
    int   dq1[$];

    int n_vec = 0;
    int n_err = 0;
    int wcnt[2];
    int maxaddr[2];
    int rounds[2];
    int img0[NA];
    int img1[NB];

    function automatic void chk(string name, int d, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, d, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_cell(int r, int c, int R, int C, bit rnd);
        if (r == 0 || r == R - 1 || c == 0 || c == C - 1) return 1;
        if (r == 1 && c == 1) return 2;
        if (r == R - 2 && c == C - 2) return 3;
        if (iabs(r - 1) + iabs(c - 1) == 1) return 0;
        if (iabs(r - (R - 2)) + iabs(c - (C - 2)) == 1) return 0;
        if (r % 2 == 0 && c % 2 == 0) return 1;
        return rnd ? 1 : 0;
    endfunction

    // Queue one complete fill whose first write is registered at edge first_cyc.
    function automatic void push_pass(int d, int first_cyc, logic [15:0] seed);
        int R = (d == 0) ? RA : RB;
        int C = (d == 0) ? CA : CB;
        int s = (seed == 16'h0) ? 'hACE1 : int'(seed);
        for (int i = 0; i < R * C; i++) begin
            exp_t e;
            bit rnd = 1'b0;
`ifdef ARENA_INIT_LFSR_EN
            rnd = ((s % 8) < 3);
            s = (s / 2) ^ (((s % 2) == 1) ? 'hB400 : 0);
`endif
            e.addr = i;
            e.data = ref_cell(i / C, i % C, R, C, rnd);
            e.cyc  = first_cyc + i;
            if (d == 0) wq0.push_back(e); else wq1.push_back(e);
        end
        if (d == 0) dq0.push_back(first_cyc + R * C);
        else        dq1.push_back(first_cyc + R * C);
        if (s == -1) $display("seed state %0d", s);
    endfunction

    function automatic void clear_q(int d);
        if (d == 0) begin wq0.delete(); dq0.delete(); end
        else        begin wq1.delete(); dq1.delete(); end
    endfunction

    function automatic int dq_size(int d);
        return (d == 0) ? dq0.size() : dq1.size();
    endfunction

    // ---------------- monitors ----------------
    task automatic observe(int d, logic we, int addr, int data, int bomb, logic dn,
                           logic bsy, int ha, int hb, int gs);
        exp_t e;
        int   x;
        if (we) begin
            wcnt[d]++;
            if (addr > maxaddr[d]) maxaddr[d] = addr;
            if (d == 0 && addr < NA) img0[addr] = data;
            if (d == 1 && addr < NB) img1[addr] = data;
            if (((d == 0) ? wq0.size() : wq1.size()) == 0) begin
                chk("unexpected_write", d, addr, -1);
            end else begin
                e = (d == 0) ? wq0.pop_front() : wq1.pop_front();
                chk("wr_addr", d, addr, e.addr);
                chk("arena_wdata", d, data, e.data);
                chk("wr_cycle", d, cyc, e.cyc);
                chk("bomb_wdata", d, bomb, 0);
                chk("busy_in_fill", d, int'(bsy), 1);
            end
        end
        if (dn) begin
            chk("wr_en_at_done", d, int'(we), 0);
            if (dq_size(d) == 0) begin
                chk("unexpected_done", d, cyc, -1);
            end else begin
                x = (d == 0) ? dq0.pop_front() : dq1.pop_front();
                chk("done_cycle", d, cyc, x);
                chk("writes_left_at_done", d, (d == 0) ? wq0.size() : wq1.size(), 0);
                chk("healthA_at_done", d, ha, 3);
                chk("healthB_at_done", d, hb, 3);
                chk("game_state_at_done", d, gs, 0);
                chk("busy_at_done", d, int'(bsy), 1);
                rounds[d]++;
                $display("round %0d dut%0d done at cycle %0d, total writes %0d, miscompares %0d",
                         rounds[d], d, cyc, wcnt[d], n_err);
            end
        end
    endtask

    always @(negedge clk)
        observe(0, if_a.wr_en, int'(if_a.wr_addr), int'(if_a.arena_wdata), int'(if_a.bomb_wdata),
                done_a, busy_a, int'(hpa_a), int'(hpb_a), int'(gs_a));

    always @(negedge clk)
        observe(1, if_b.wr_en, int'(if_b.wr_addr), int'(if_b.arena_wdata), int'(if_b.bomb_wdata),
                done_b, busy_b, int'(hpa_b), int'(hpb_b), int'(gs_b));

    // ---------------- driver helpers (called at posedge + #1) ----------------
    function automatic logic busy_of(int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic we_of(int d);
        return (d == 0) ? if_a.wr_en : if_b.wr_en;
    endfunction

    function automatic logic done_of(int d);
        return (d == 0) ? done_a : done_b;
    endfunction

    function automatic logic [15:0] seed_of(int d);
        return (d == 0) ? seed_a : seed_b;
    endfunction

    function automatic void set_start(int d, logic v);
        if (d == 0) start_a = v; else start_b = v;
    endfunction

    function automatic void set_rst(int d, logic v);
        if (d == 0) rst_a = v; else rst_b = v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int d, int limit);
        int n = 0;
        while (dq_size(d) != 0 && n < limit) begin
            tick();
            n++;
        end
        if (dq_size(d) != 0) begin
            chk("done_timeout", d, n, -1);
            clear_q(d);
        end
    endtask

    task automatic wait_writes(int d, int target, int limit);
        int n = 0;
        while (wcnt[d] < target && n < limit) begin
            tick();
            n++;
        end
        if (wcnt[d] < target) chk("write_timeout", d, wcnt[d], target);
    endtask

    task automatic start_round(int d, logic [15:0] seed);
        if (d == 0) seed_a = seed; else seed_b = seed;
        set_start(d, 1'b1);
        push_pass(d, cyc + 2, seed);
        tick();
        set_start(d, 1'b0);
        chk("busy_at_start_edge", d, int'(busy_of(d)), 0);
        chk("wr_en_at_start_edge", d, int'(we_of(d)), 0);
        tick();
        chk("busy_rise", d, int'(busy_of(d)), 1);
    endtask

    task automatic stray_start(int d);
        set_start(d, 1'b1);
        tick();
        set_start(d, 1'b0);
    endtask

    task automatic mid_reset(int d);
        set_rst(d, 1'b1);
        tick();
        clear_q(d);
        chk("wr_en_after_rst", d, int'(we_of(d)), 0);
        chk("done_after_rst", d, int'(done_of(d)), 0);
        chk("busy_after_rst", d, int'(busy_of(d)), 1);
        set_rst(d, 1'b0);
        push_pass(d, cyc + 1, seed_of(d));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, tgt, d, n;
        wcnt[0] = 0; wcnt[1] = 0;
        maxaddr[0] = -1; maxaddr[1] = -1;
        rounds[0] = 0; rounds[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 0, int'(busy_a), 1);
        chk("rst_done", 0, int'(done_a), 0);
        chk("rst_wr_en", 0, int'(if_a.wr_en), 0);
        chk("rst_wr_addr", 0, int'(if_a.wr_addr), 0);
        chk("rst_healthA", 0, int'(hpa_a), 3);
        chk("rst_healthB", 0, int'(hpb_a), 3);
        chk("rst_game_state", 0, int'(gs_a), 0);
        chk("rst_wr_en", 1, int'(if_b.wr_en), 0);
        chk("rst_busy", 1, int'(busy_b), 1);

        // Power-on fill: both DUTs start from the reset release.
        seed_a = 16'($urandom);
        seed_b = 16'h0000;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        push_pass(0, cyc + 1, seed_a);
        push_pass(1, cyc + 1, seed_b);
        wait_done(0, NA + 20);
        wait_done(1, NB + 20);

        chk("img_a_addr11_playerA", 0, img0[11], 2);
        chk("img_a_addr88_playerB", 0, img0[88], 3);
        chk("img_a_addr0_border", 0, img0[0], 1);
        chk("img_a_addr9_border", 0, img0[9], 1);
        chk("img_a_addr90_border", 0, img0[90], 1);
        chk("img_a_addr99_border", 0, img0[99], 1);
        chk("img_a_addr22_pillar", 0, img0[22], 1);
        chk("img_a_addr12_safe", 0, img0[12], 0);
        chk("img_a_write_count", 0, wcnt[0], NA);
        chk("img_a_max_addr", 0, maxaddr[0], NA - 1);
        chk("img_b_addr76_playerB", 1, img1[76], 3);
        chk("img_b_addr14_playerA", 1, img1[14], 2);
        chk("img_b_addr12_border", 1, img1[12], 1);
        chk("img_b_addr28_pillar", 1, img1[28], 1);
        chk("img_b_write_count", 1, wcnt[1], NB);
        chk("img_b_max_addr", 1, maxaddr[1], NB - 1);

        // Rounds from idle, some with an ignored start mid-fill.
        for (int r = 0; r < 6; r++) begin
            logic [15:0] sd;
            d = r % 2;
            n = $urandom_range(1, 15);
            repeat (n) tick();
            chk("idle_busy", d, int'(busy_of(d)), 0);
            chk("idle_done", d, int'(done_of(d)), 0);
            sd = (r == 2) ? 16'h0000 : (r == 4) ? 16'hACE1 : 16'($urandom);
            base = wcnt[d];
            start_round(d, sd);
            if (r < 4) begin
                tgt = (r == 0) ? 40 : $urandom_range(2, ((d == 0) ? NA : NB) - 5);
                wait_writes(d, base + tgt, 200);
                stray_start(d);
            end
            wait_done(d, NB + NA);
            repeat (3) tick();
        end

        // Reset in the middle of a fill.
        for (int r = 0; r < 3; r++) begin
            d = (r == 2) ? 1 : 0;
            repeat ($urandom_range(1, 10)) tick();
            base = wcnt[d];
            start_round(d, 16'($urandom));
            tgt = (r == 0) ? 57 : $urandom_range(2, ((d == 0) ? NA : NB) - 3);
            wait_writes(d, base + tgt, 200);
            mid_reset(d);
            wait_done(d, NA + NB);
            repeat (3) tick();
        end

        // Quiet period: monitors flag any stray write or done.
        repeat (20) tick();
        chk("final_busy", 0, int'(busy_a), 0);
        chk("final_busy", 1, int'(busy_b), 0);
        chk("final_pending_writes", 0, wq0.size(), 0);
        chk("final_pending_writes", 1, wq1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
